tlb_maint_ctrl: RTL and testbench
=================================

Name: tlb_maint_ctrl

Overview:
- Sequences all TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) against the MMU's register-based TLB array.
- Reads entries through a single indexed read port and writes entries through the MMU's one-hot `tlb_write_req_t` port.
- Multi-entry operations (search, invalidate) sweep one entry per cycle.
- Sits between the CSR/commit-side maintenance unit and the mmu block.

Parameters:
- TLB_ENTRY_NUM, `_TLB_ENTRY_NUM (32): number of TLB entries; power of two, at least 2.
- IDX_W, $clog2(TLB_ENTRY_NUM): width of an entry index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  maintenance request.
- req_ready  out  1  controller idle; request accepted when req_valid && req_ready.
- req_op  in  3  operation: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV.
- req_inv_op  in  5  INVTLB op code (valid 0..6).
- req_asid  in  10  ASID for SRCH/INV.
- req_va  in  32  VA for SRCH and INV ops 5/6.
- req_index  in  IDX_W  entry index for RD/WR.
- req_entry  in  tlb_entry_t  entry to write for WR/FILL.
- ent_rd_idx  out  IDX_W  array read index.
- ent_rd_entry  in  tlb_entry_t  combinational array read data at ent_rd_idx.
- tlb_write_req_o  out  tlb_write_req_t  one-hot write enable plus write entry to the mmu.
- resp_valid  out  1  one-cycle completion pulse.
- resp_hit  out  1  SRCH found a match.
- resp_index  out  IDX_W  hit index (SRCH) or written index (WR/FILL).
- resp_entry  out  tlb_entry_t  entry read (RD).
- resp_err  out  1  INV with req_inv_op > 6.

Behaviour:
- Reset values (async): state IDLE, fill_ptr 0, scan counter 0. All outputs 0 except req_ready=1. tlb_write_req_o one-hot is all zero.
- FSM states: IDLE, SCAN, RESP.
  - IDLE: req_ready=1. On accept, latch op and operands, then:
    - RD, WR, FILL, and INV with a bad op code → RESP.
    - SRCH and INV → SCAN with counter=0.
  - WR: the write fires in the accept cycle at req_index (write one-hot bit set, entry = req_entry).
  - FILL: the write fires in the accept cycle at fill_ptr; fill_ptr increments mod TLB_ENTRY_NUM (N-1 wraps to 0). resp_index = the index used.
  - RD: ent_rd_idx=req_index in the accept cycle; ent_rd_entry is registered into resp_entry.
  - SCAN: one cycle per entry i, with ent_rd_idx=i.
    - Match function, same as lookup: e && (g || asid==req_asid) && VPPN compare (huge page: va[31:22] vs vppn[18:9]; else va[31:13] vs vppn).
    - SRCH: on the first match, latch hit=1 and index=i and go to RESP. After i=N-1 with no match, go to RESP with hit=0.
    - INV: predicate per inv_op:
      - 0/1: all entries.
      - 2: g=1.
      - 3: g=0.
      - 4: g=0 && asid match.
      - 5: g=0 && asid match && va match.
      - 6: (g || asid match) && va match.
    - INV on a predicate hit: write entry i in the same cycle with key.e=0 and all other fields as read.
    - INV always sweeps all N entries, then goes to RESP.
  - RESP: resp_valid=1 for exactly one cycle, resp_* held for that cycle only, then IDLE.
- Latency from the accept cycle T:
  - RD, WR, FILL, bad INV: resp at T+1.
  - SRCH hit at index k: resp at T+k+2. SRCH miss: resp at T+N+1.
  - INV: resp at T+N+1.
- Responses have no backpressure. req_ready=0 in SCAN and RESP, so there is never more than one op in flight.
- At most one bit of the write one-hot is set in any cycle. The one-hot is zero in every cycle without a write.
- A new request cannot be accepted in the RESP cycle; the earliest next accept is the following cycle.
- req_op 5..7: treated as a no-op. resp_valid at T+1 with resp_err=1 and no write.
- Reset mid-SCAN: immediate return to IDLE. The cycle in which rst is high issues no write. fill_ptr returns to 0.
- resp_entry is 0 for every op except RD.

Test Plan:
- After reset, WR index 5 with entry {e=1, asid=3, vppn=0x12345}, then RD index 5 → the write one-hot has only bit 5 set for one cycle. The RD response at T+1 returns the same entry.
- FILL ×33 with N=32 → writes go to indexes 0..31, then index 0. resp_index follows the same sequence.
- SRCH va=0x2468A000, asid=3, with a matching 4KB entry at index 7 and another at index 20 → resp_hit=1, resp_index=7, resp_valid at T+9.
- SRCH with no match → resp_hit=0 at T+33.
- INV op 4 with asid=3, entries 2 (g=0, asid 3), 4 (g=1, asid 3) and 9 (g=0, asid 1) valid → only entry 2 is written with e=0; resp at T+33.
- INV op 9 → resp_err=1 at T+1 with no write. INV op 6 on a huge-page entry with va[31:22] equal to vppn[18:9] → that entry is cleared.
- Assert rst during a SCAN at i=10 → no further writes, req_ready=1 in the next cycle, and the next FILL writes index 0.

Source files
------------

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against the
// MMU's register-based TLB array via one read port and a one-hot write port.

package tlb_maint_pkg;

  localparam int unsigned TLB_ENTRY_NUM = 32;
  localparam int unsigned IDX_W = $clog2(TLB_ENTRY_NUM);

  typedef struct packed {
    logic        e;
    logic        g;
    logic        huge;   // 4MB page: only vppn[18:9] participates in the compare
    logic [9:0]  asid;
    logic [18:0] vppn;
  } tlb_key_t;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_data_t;

  typedef struct packed {
    tlb_key_t  key;
    tlb_data_t data;
  } tlb_entry_t;

  typedef struct packed {
    logic [TLB_ENTRY_NUM-1:0] we;
    tlb_entry_t               entry;
  } tlb_write_req_t;

endpackage

module tlb_maint_ctrl
  import tlb_maint_pkg::tlb_entry_t;
  import tlb_maint_pkg::tlb_write_req_t;
#(
  parameter  int unsigned TLB_ENTRY_NUM = tlb_maint_pkg::TLB_ENTRY_NUM,
  localparam int unsigned IDX_W         = $clog2(TLB_ENTRY_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [4:0]           req_inv_op,
  input  logic [9:0]           req_asid,
  input  logic [31:0]          req_va,
  input  logic [IDX_W-1:0]     req_index,
  input  tlb_entry_t           req_entry,
  output logic [IDX_W-1:0]     ent_rd_idx,
  input  tlb_entry_t           ent_rd_entry,
  output tlb_write_req_t       tlb_write_req_o,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [IDX_W-1:0]     resp_index,
  output tlb_entry_t           resp_entry,
  output logic                 resp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRY_NUM - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       inv_op_q, inv_op_d;
  logic [9:0]       asid_q, asid_d;
  logic [18:0]      vpn_q, vpn_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] fill_ptr_q, fill_ptr_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  tlb_entry_t       entry_q, entry_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] rd_idx;
  tlb_write_req_t   wr_req;
  tlb_entry_t       cleared;
  logic             asid_m;
  logic             va_m;
  logic             srch_m;
  logic             inv_m;
  logic             unused_va;

  assign unused_va = ^req_va[12:0];

  // Match terms for the entry currently presented on the read port
  always_comb begin
    asid_m = (ent_rd_entry.key.asid == asid_q);
    if (ent_rd_entry.key.huge) begin
      va_m = (vpn_q[18:9] == ent_rd_entry.key.vppn[18:9]);
    end else begin
      va_m = (vpn_q == ent_rd_entry.key.vppn);
    end
    srch_m = ent_rd_entry.key.e && (ent_rd_entry.key.g || asid_m) && va_m;
    case (inv_op_q)
      5'd0, 5'd1: inv_m = 1'b1;
      5'd2:       inv_m = ent_rd_entry.key.g;
      5'd3:       inv_m = !ent_rd_entry.key.g;
      5'd4:       inv_m = !ent_rd_entry.key.g && asid_m;
      5'd5:       inv_m = !ent_rd_entry.key.g && asid_m && va_m;
      5'd6:       inv_m = (ent_rd_entry.key.g || asid_m) && va_m;
      default:    inv_m = 1'b0;
    endcase
    cleared       = ent_rd_entry;
    cleared.key.e = 1'b0;
  end

  // Next-state, operand latching, read index and write port
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    inv_op_d   = inv_op_q;
    asid_d     = asid_q;
    vpn_d      = vpn_q;
    cnt_d      = cnt_q;
    fill_ptr_d = fill_ptr_q;
    hit_d      = hit_q;
    idx_d      = idx_q;
    entry_d    = entry_q;
    err_d      = err_q;
    rd_idx     = cnt_q;
    wr_req     = '0;

    case (state_q)
      S_IDLE: begin
        rd_idx = req_index;
        if (req_valid) begin
          op_d     = req_op;
          inv_op_d = req_inv_op;
          asid_d   = req_asid;
          vpn_d    = req_va[31:13];
          cnt_d    = '0;
          hit_d    = 1'b0;
          idx_d    = '0;
          entry_d  = '0;
          err_d    = 1'b0;
          state_d  = S_RESP;
          case (req_op)
            OP_SRCH: state_d = S_SCAN;
            OP_RD:   entry_d = ent_rd_entry;
            OP_WR: begin
              wr_req.we[req_index] = 1'b1;
              wr_req.entry         = req_entry;
              idx_d                = req_index;
            end
            OP_FILL: begin
              wr_req.we[fill_ptr_q] = 1'b1;
              wr_req.entry          = req_entry;
              idx_d                 = fill_ptr_q;
              fill_ptr_d            = IDX_W'(fill_ptr_q + 1'b1);
            end
            OP_INV: begin
              if (req_inv_op > 5'd6) begin
                err_d = 1'b1;
              end else begin
                state_d = S_SCAN;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      S_SCAN: begin
        rd_idx = cnt_q;
        if (op_q == OP_SRCH) begin
          if (srch_m) begin
            hit_d   = 1'b1;
            idx_d   = cnt_q;
            state_d = S_RESP;
          end else if (cnt_q == LAST_IDX) begin
            state_d = S_RESP;
          end else begin
            cnt_d = IDX_W'(cnt_q + 1'b1);
          end
        end else begin
          if (inv_m) begin
            wr_req.we[cnt_q] = 1'b1;
            wr_req.entry     = cleared;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = S_RESP;
          end else begin
            cnt_d = IDX_W'(cnt_q + 1'b1);
          end
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      wr_req = '0;
    end
  end

  // State and operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      inv_op_q   <= '0;
      asid_q     <= '0;
      vpn_q      <= '0;
      cnt_q      <= '0;
      fill_ptr_q <= '0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      entry_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      inv_op_q   <= inv_op_d;
      asid_q     <= asid_d;
      vpn_q      <= vpn_d;
      cnt_q      <= cnt_d;
      fill_ptr_q <= fill_ptr_d;
      hit_q      <= hit_d;
      idx_q      <= idx_d;
      entry_q    <= entry_d;
      err_q      <= err_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign ent_rd_idx      = rd_idx;
  assign tlb_write_req_o = wr_req;
  assign resp_valid      = (state_q == S_RESP);
  assign resp_hit        = resp_valid && hit_q;
  assign resp_index      = resp_valid ? idx_q : '0;
  assign resp_entry      = resp_valid ? entry_q : '0;
  assign resp_err        = resp_valid && err_q;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Scoreboard bench for tlb_maint_ctrl: reference model predicts writes and
// responses at issue time; a monitor thread checks them as the DUT emits them.

module tb_tlb_maint_ctrl;
  import tlb_maint_pkg::*;

  localparam int unsigned N  = TLB_ENTRY_NUM;
  localparam int unsigned IW = IDX_W;

  typedef struct {
    int unsigned cyc;
    logic        hit;
    logic [IW-1:0] idx;
    tlb_entry_t  ent;
    logic        err;
  } resp_t;

  typedef struct {
    int unsigned cyc;
    logic [IW-1:0] idx;
    tlb_entry_t  ent;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           mem_clr = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [2:0]     req_op = '0;
  logic [4:0]     req_inv_op = '0;
  logic [9:0]     req_asid = '0;
  logic [31:0]    req_va = '0;
  logic [IW-1:0]  req_index = '0;
  tlb_entry_t     req_entry = '0;
  logic [IW-1:0]  ent_rd_idx;
  tlb_entry_t     ent_rd_entry;
  tlb_write_req_t tlb_write_req_o;
  logic           resp_valid;
  logic           resp_hit;
  logic [IW-1:0]  resp_index;
  tlb_entry_t     resp_entry;
  logic           resp_err;

  tlb_entry_t  tlb_mem [N];
  tlb_entry_t  ref_mem [N];
  int unsigned ref_fill = 0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  resp_t       rq[$];
  wr_t         wq[$];

  tlb_maint_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_inv_op(req_inv_op), .req_asid(req_asid),
    .req_va(req_va), .req_index(req_index), .req_entry(req_entry),
    .ent_rd_idx(ent_rd_idx), .ent_rd_entry(ent_rd_entry),
    .tlb_write_req_o(tlb_write_req_o),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_index(resp_index),
    .resp_entry(resp_entry), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the MMU's TLB array
  assign ent_rd_entry = tlb_mem[ent_rd_idx];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mem_clr) tlb_mem[i] <= '0;
      else if (tlb_write_req_o.we[i]) tlb_mem[i] <= tlb_write_req_o.entry;
    end
  end

  function automatic tlb_entry_t mk(input logic e, input logic g, input logic huge,
                                    input logic [9:0] asid, input logic [18:0] vppn);
    tlb_entry_t t;
    t = '0;
    t.key.e = e; t.key.g = g; t.key.huge = huge; t.key.asid = asid; t.key.vppn = vppn;
    t.data.ppn = 20'(vppn) ^ 20'hA5A5A;
    t.data.v = 1'b1;
    return t;
  endfunction

  function automatic logic va_match(input tlb_entry_t t, input logic [31:0] va);
    logic [18:0] v;
    logic [18:0] p;
    v = va[31:13];
    p = t.key.vppn;
    if (t.key.huge) return v[18:9] == p[18:9];
    return v == p;
  endfunction

  task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: derive every write and the response for one request issued in cycle t
  task automatic model(input logic [2:0] op, input logic [4:0] inv, input logic [9:0] asid,
                       input logic [31:0] va, input logic [IW-1:0] idx, input tlb_entry_t ent,
                       input int unsigned t);
    resp_t r;
    wr_t   w;
    logic  p, am, g;
    r = '{cyc: t + 1, hit: 1'b0, idx: '0, ent: '0, err: 1'b0};
    case (op)
      3'd0: begin
        r.cyc = t + N + 1;
        for (int i = 0; i < N; i++) begin
          if (ref_mem[i].key.e && (ref_mem[i].key.g || ref_mem[i].key.asid == asid) &&
              va_match(ref_mem[i], va)) begin
            r.cyc = t + 2 + i; r.hit = 1'b1; r.idx = IW'(i);
            break;
          end
        end
      end
      3'd1: r.ent = ref_mem[idx];
      3'd2: begin
        w = '{cyc: t, idx: idx, ent: ent}; wq.push_back(w);
        ref_mem[idx] = ent; r.idx = idx;
      end
      3'd3: begin
        w = '{cyc: t, idx: IW'(ref_fill), ent: ent}; wq.push_back(w);
        ref_mem[ref_fill] = ent; r.idx = IW'(ref_fill);
        ref_fill = (ref_fill + 1) % N;
      end
      3'd4: begin
        if (inv > 5'd6) r.err = 1'b1;
        else begin
          r.cyc = t + N + 1;
          for (int i = 0; i < N; i++) begin
            g  = ref_mem[i].key.g;
            am = (ref_mem[i].key.asid == asid);
            case (inv)
              5'd0, 5'd1: p = 1'b1;
              5'd2: p = g;
              5'd3: p = !g;
              5'd4: p = !g && am;
              5'd5: p = !g && am && va_match(ref_mem[i], va);
              default: p = (g || am) && va_match(ref_mem[i], va);
            endcase
            if (p) begin
              ref_mem[i].key.e = 1'b0;
              w = '{cyc: t + 1 + i, idx: IW'(i), ent: ref_mem[i]}; wq.push_back(w);
            end
          end
        end
      end
      default: r.err = 1'b1;
    endcase
    rq.push_back(r);
  endtask

  // Monitor: compare DUT writes and responses against the scoreboard queues
  task automatic monitor_step();
    wr_t   w;
    resp_t r;
    int    widx;
    if (tlb_write_req_o.we != '0) begin
      widx = 0;
      for (int i = 0; i < N; i++) if (tlb_write_req_o.we[i]) widx = i;
      check("wr_onehot", $onehot(tlb_write_req_o.we), 64'(tlb_write_req_o.we), 64'(1) << widx);
      if (wq.size() == 0) begin
        check("wr_unexpected", 1'b0, 64'(widx), 64'hFFFF);
      end else begin
        w = wq.pop_front();
        check("wr_cycle", cyc == w.cyc, 64'(cyc), 64'(w.cyc));
        check("wr_index", widx == int'(w.idx), 64'(widx), 64'(w.idx));
        check("wr_entry", tlb_write_req_o.entry == w.ent, 64'(tlb_write_req_o.entry), 64'(w.ent));
      end
    end
    if (resp_valid) begin
      if (rq.size() == 0) begin
        check("resp_unexpected", 1'b0, 64'(1), 64'(0));
      end else begin
        r = rq.pop_front();
        check("resp_cycle", cyc == r.cyc, 64'(cyc), 64'(r.cyc));
        check("resp_hit", resp_hit == r.hit, 64'(resp_hit), 64'(r.hit));
        check("resp_index", resp_index == r.idx, 64'(resp_index), 64'(r.idx));
        check("resp_entry", resp_entry == r.ent, 64'(resp_entry), 64'(r.ent));
        check("resp_err", resp_err == r.err, 64'(resp_err), 64'(r.err));
      end
    end else begin
      check("resp_idle_zero", !resp_hit && !resp_err && resp_index == '0 && resp_entry == '0,
            64'({resp_hit, resp_err, resp_index}), 64'(0));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 3 * N) begin
      @(posedge clk); #1; n++;
    end
    if (rq.size() != 0 || wq.size() != 0) begin
      check("drain_timeout", 1'b0, 64'(rq.size() + wq.size()), 64'(0));
      rq.delete(); wq.delete();
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] inv, input logic [9:0] asid,
                       input logic [31:0] va, input logic [IW-1:0] idx, input tlb_entry_t ent);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (!req_ready && n < 3 * N) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready", req_ready, 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_op = op; req_inv_op = inv; req_asid = asid;
    req_va = va; req_index = idx; req_entry = ent;
    model(op, inv, asid, va, idx, ent, cyc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ready_low_busy", !req_ready, 64'(req_ready), 64'(0));
    drain();
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) issue(3'd2, 5'd0, 10'd0, 32'd0, IW'(i), '0);
  endtask

  logic [63:0] rnd;
  tlb_entry_t  te;
  logic [31:0] va_v;
  logic [18:0] vp;
  int unsigned t0;

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 64'(req_ready), 64'(1));
    check("rst_resp_valid", !resp_valid, 64'(resp_valid), 64'(0));
    check("rst_we", tlb_write_req_o == '0, 64'(tlb_write_req_o.we), 64'(0));
    check("rst_rd_idx", ent_rd_idx == '0, 64'(ent_rd_idx), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;

    // Write then read back
    te = mk(1'b1, 1'b0, 1'b0, 10'd3, 19'h12345);
    issue(3'd2, 5'd0, 10'd0, 32'd0, IW'(5), te);
    issue(3'd1, 5'd0, 10'd0, 32'd0, IW'(5), '0);

    // Fill pointer wrap
    for (int k = 0; k < N + 1; k++) begin
      rnd = {$urandom(), $urandom()};
      te = rnd[57:0];
      issue(3'd3, 5'd0, 10'd0, 32'd0, '0, te);
    end

    // Search: first of two matching entries wins
    clear_all();
    issue(3'd2, 5'd0, 10'd0, 32'd0, IW'(7),  mk(1'b1, 1'b0, 1'b0, 10'd3, 19'h12345));
    issue(3'd2, 5'd0, 10'd0, 32'd0, IW'(20), mk(1'b1, 1'b0, 1'b0, 10'd3, 19'h12345));
    issue(3'd0, 5'd0, 10'd3, 32'h2468A000, '0, '0);
    issue(3'd0, 5'd0, 10'd3, 32'h11110000, '0, '0);

    // INVTLB op 4 keeps global and other-ASID entries
    clear_all();
    issue(3'd2, 5'd0, 10'd0, 32'd0, IW'(2), mk(1'b1, 1'b0, 1'b0, 10'd3, 19'h00111));
    issue(3'd2, 5'd0, 10'd0, 32'd0, IW'(4), mk(1'b1, 1'b1, 1'b0, 10'd3, 19'h00222));
    issue(3'd2, 5'd0, 10'd0, 32'd0, IW'(9), mk(1'b1, 1'b0, 1'b0, 10'd1, 19'h00333));
    issue(3'd4, 5'd4, 10'd3, 32'd0, '0, '0);

    // Bad INVTLB code, then op 6 on a huge page
    issue(3'd4, 5'd9, 10'd3, 32'd0, '0, '0);
    va_v = 32'hABC12345;
    vp = {va_v[31:22], 9'h0AB};
    issue(3'd2, 5'd0, 10'd0, 32'd0, IW'(12), mk(1'b1, 1'b1, 1'b1, 10'd7, vp));
    issue(3'd4, 5'd6, 10'd2, va_v, '0, '0);
    issue(3'd1, 5'd0, 10'd0, 32'd0, IW'(12), '0);
    issue(3'd6, 5'd0, 10'd0, 32'd0, '0, '0);

    // Randomized mix over a small key space so hits are frequent
    for (int k = 0; k < 150; k++) begin
      vp = 19'($urandom_range(0, 3)) << 9 | 19'($urandom_range(0, 1));
      te = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              10'($urandom_range(0, 3)), vp);
      te.data = 26'($urandom());
      va_v = {vp, 13'($urandom())};
      case ($urandom_range(0, 9))
        0, 1:    issue(3'd2, 5'd0, 10'd0, 32'd0, IW'($urandom_range(0, N - 1)), te);
        2, 3:    issue(3'd3, 5'd0, 10'd0, 32'd0, '0, te);
        4:       issue(3'd1, 5'd0, 10'd0, 32'd0, IW'($urandom_range(0, N - 1)), '0);
        5, 6:    issue(3'd0, 5'd0, 10'($urandom_range(0, 3)), va_v, '0, '0);
        7, 8:    issue(3'd4, 5'($urandom_range(0, 9)), 10'($urandom_range(0, 3)), va_v, '0, '0);
        default: issue(3'($urandom_range(5, 7)), 5'd0, 10'd0, 32'd0, '0, '0);
      endcase
    end

    // Reset in the middle of an invalidate-all sweep at entry 10
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd4; req_inv_op = 5'd0;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      ref_mem[i].key.e = 1'b0;
      wq.push_back('{cyc: t0 + 1 + i, idx: IW'(i), ent: ref_mem[i]});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_fill = 0;
    check("post_rst_ready", req_ready, 64'(req_ready), 64'(1));
    check("post_rst_writes", wq.size() == 0, 64'(wq.size()), 64'(0));
    wq.delete();
    issue(3'd3, 5'd0, 10'd0, 32'd0, '0, mk(1'b1, 1'b0, 1'b0, 10'd5, 19'h7FFFF));
    issue(3'd1, 5'd0, 10'd0, 32'd0, IW'(10), '0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
